// File: rtl/countdown_digit_ctrl.sv
// countdown_digit_ctrl: two-digit BCD countdown timer (00..99 s) for the game display.
// Divides clk into one-second ticks, decrements the BCD value, and applies
// start/pause/load/bonus commands. It flags the low-time warning and expiry.
module countdown_digit_ctrl #(
    parameter int TICK_DIV    = 25000000,
    parameter int START_TENS  = 3,
    parameter int START_ONES  = 0,
    parameter int BONUS       = 5,
    parameter int WARN_THRESH = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       pause,
    input  logic       load,
    input  logic [3:0] load_tens,
    input  logic [3:0] load_ones,
    input  logic       add_bonus,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       running,
    output logic       warn,
    output logic       expired,
    output logic       expired_pulse
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX  = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
    localparam logic [PW-1:0] PRESC_ZERO = PW'(0);
    localparam logic [7:0]    BONUS_W    = 8'(BONUS);
    localparam logic [7:0]    WARN_W     = 8'(WARN_THRESH);
    localparam logic [3:0]    RST_TENS   = 4'(START_TENS);
    localparam logic [3:0]    RST_ONES   = 4'(START_ONES);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    state_t        state_r, state_s;
    logic [PW-1:0] presc_r, presc_s;
    logic [3:0]    tens_r, tens_s;
    logic [3:0]    ones_r, ones_s;
    logic          running_r, running_s;
    logic          warn_r, warn_s;
    logic          expired_r, expired_s;
    logic          pulse_r, pulse_s;
    logic [7:0]    cur_val_s;
    logic [7:0]    nxt_val_s;
    logic [7:0]    sum_s;
    logic [7:0]    bcd_s;
    logic          tick_s;
    logic          start_go_s;
    logic          pause_go_s;

    // BCD digit pair to binary value (tens*10 + ones)
    function automatic logic [7:0] bcd_to_bin(input logic [3:0] t, input logic [3:0] o);
        return {1'b0, t, 3'b000} + {3'b000, t, 1'b0} + {4'b0000, o};
    endfunction

    // Binary 0..99 to BCD by repeated subtraction of ten (only on the bonus path)
    function automatic logic [7:0] bin_to_bcd(input logic [7:0] v);
        logic [7:0] rem;
        logic [3:0] t;
        rem = v;
        t   = 4'd0;
        for (int i = 0; i < 9; i++) begin
            if (rem >= 8'd10) begin
                rem = rem - 8'd10;
                t   = t + 4'd1;
            end else begin
                rem = rem;
            end
        end
        return {t, rem[3:0]};
    endfunction

    // Clamp an out-of-range load digit to 9
    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    assign cur_val_s  = bcd_to_bin(tens_r, ones_r);
    assign tick_s     = (state_r == ST_RUN) && (presc_r == PRESC_MAX);
    assign start_go_s = start && ((state_r == ST_IDLE) || (state_r == ST_PAUSED));
    assign pause_go_s = pause && (state_r == ST_RUN);

    // Next-state, next-value and next-flag logic with command priority load > start > pause > bonus/tick
    always_comb begin
        state_s = state_r;
        presc_s = presc_r;
        tens_s  = tens_r;
        ones_s  = ones_r;
        pulse_s = 1'b0;
        sum_s   = 8'd0;
        bcd_s   = 8'd0;

        if (load) begin
            tens_s  = clamp_digit(load_tens);
            ones_s  = clamp_digit(load_ones);
            state_s = ST_IDLE;
            presc_s = PRESC_ZERO;
        end else if (start_go_s) begin
            case (state_r)
                ST_IDLE: begin
                    if (cur_val_s == 8'd0) begin
                        state_s = ST_EXPIRED;
                        pulse_s = 1'b1;
                    end else begin
                        state_s = ST_RUN;
                        presc_s = PRESC_ZERO;
                    end
                end
                ST_PAUSED: state_s = ST_RUN;
                default:   state_s = state_r;
            endcase
        end else if (pause_go_s) begin
            // A tick on this cycle is deferred: prescaler parks at its last count
            state_s = ST_PAUSED;
            presc_s = tick_s ? presc_r : (presc_r + PRESC_ONE);
        end else if ((state_r == ST_RUN) || (state_r == ST_PAUSED)) begin
            if (state_r == ST_RUN) begin
                presc_s = tick_s ? PRESC_ZERO : (presc_r + PRESC_ONE);
            end else begin
                presc_s = presc_r;
            end
            if (add_bonus) begin
                // Bonus and tick together net BONUS-1; never reaches 00 since BONUS >= 1
                sum_s  = cur_val_s + BONUS_W - (tick_s ? 8'd1 : 8'd0);
                sum_s  = (sum_s > 8'd99) ? 8'd99 : sum_s;
                bcd_s  = bin_to_bcd(sum_s);
                tens_s = bcd_s[7:4];
                ones_s = bcd_s[3:0];
            end else if (tick_s) begin
                if (ones_r != 4'd0) begin
                    ones_s = ones_r - 4'd1;
                    tens_s = tens_r;
                end else begin
                    ones_s = 4'd9;
                    tens_s = tens_r - 4'd1;
                end
                if ((tens_r == 4'd0) && (ones_r == 4'd1)) begin
                    state_s = ST_EXPIRED;
                    pulse_s = 1'b1;
                end else begin
                    state_s = state_r;
                end
            end else begin
                tens_s = tens_r;
                ones_s = ones_r;
            end
        end else begin
            state_s = state_r;
        end

        nxt_val_s = bcd_to_bin(tens_s, ones_s);
        running_s = (state_s == ST_RUN);
        expired_s = (state_s == ST_EXPIRED);
        warn_s    = ((state_s == ST_RUN) || (state_s == ST_PAUSED)) && (nxt_val_s <= WARN_W);
    end

    // State, prescaler, digit and flag registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            presc_r   <= PRESC_ZERO;
            tens_r    <= RST_TENS;
            ones_r    <= RST_ONES;
            running_r <= 1'b0;
            warn_r    <= 1'b0;
            expired_r <= 1'b0;
            pulse_r   <= 1'b0;
        end else begin
            state_r   <= state_s;
            presc_r   <= presc_s;
            tens_r    <= tens_s;
            ones_r    <= ones_s;
            running_r <= running_s;
            warn_r    <= warn_s;
            expired_r <= expired_s;
            pulse_r   <= pulse_s;
        end
    end

    assign tens          = tens_r;
    assign ones          = ones_r;
    assign running       = running_r;
    assign warn          = warn_r;
    assign expired       = expired_r;
    assign expired_pulse = pulse_r;

endmodule

// File: tb/tb_countdown_digit_ctrl.sv
// Scoreboard bench for countdown_digit_ctrl with TICK_DIV=4.
// Stimulus drives inputs on the falling edge and queues the hand-computed
// response expected after the next rising edge; a monitor pops and compares.
module tb_countdown_digit_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_tens = 4'd0;
    logic [3:0] load_ones = 4'd0;
    logic       add_bonus = 1'b0;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       running;
    logic       warn;
    logic       expired;
    logic       expired_pulse;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic        chk;
        logic [11:0] ev;
        string       nm;
    } exp_t;

    exp_t sb_q[$];

    countdown_digit_ctrl #(
        .TICK_DIV(4), .START_TENS(3), .START_ONES(0), .BONUS(5), .WARN_THRESH(5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .load(load),
        .load_tens(load_tens), .load_ones(load_ones), .add_bonus(add_bonus),
        .tens(tens), .ones(ones), .running(running), .warn(warn),
        .expired(expired), .expired_pulse(expired_pulse)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] ex(input logic [3:0] t, input logic [3:0] o,
                                       input logic r, input logic w,
                                       input logic x, input logic p);
        return {t, o, r, w, x, p};
    endfunction

    // Monitor: one expectation per clock; compare the flagged ones just after the edge
    always @(posedge clk) begin
        exp_t e;
        logic [11:0] act;
        #1;
        if (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            act = {tens, ones, running, warn, expired, expired_pulse};
            if (e.chk) begin
                n_vec++;
                if (act !== e.ev) begin
                    n_bad++;
                    $display("FAIL %s: got tens=%h ones=%h run=%b warn=%b exp=%b pulse=%b, want tens=%h ones=%h run=%b warn=%b exp=%b pulse=%b",
                             e.nm, act[11:8], act[7:4], act[3], act[2], act[1], act[0],
                             e.ev[11:8], e.ev[7:4], e.ev[3], e.ev[2], e.ev[1], e.ev[0]);
                end
            end
        end
    end

    task automatic cyc(input logic rs, input logic st, input logic pa, input logic ld,
                       input logic [3:0] lt, input logic [3:0] lo, input logic bo,
                       input logic chk, input logic [11:0] ev, input string nm);
        @(negedge clk);
        rst_n = rs; start = st; pause = pa; load = ld;
        load_tens = lt; load_ones = lo; add_bonus = bo;
        sb_q.push_back('{chk, ev, nm});
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 12'd0, "");
    endtask

    task automatic nopc(input logic [11:0] ev, input string nm);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1, ev, nm);
    endtask

    task automatic do_start(input logic [11:0] ev, input string nm);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1, ev, nm);
    endtask

    task automatic do_pause(input logic [11:0] ev, input string nm);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1, ev, nm);
    endtask

    task automatic do_load(input logic [3:0] lt, input logic [3:0] lo, input logic [11:0] ev, input string nm);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, lt, lo, 1'b0, 1'b1, ev, nm);
    endtask

    task automatic do_bonus(input logic [11:0] ev, input string nm);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1, ev, nm);
    endtask

    initial begin
        // Reset and first ticks
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1, ex(4'd3, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0), "reset");
        do_start(ex(4'd3, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0), "start_run");
        nop(2);
        nopc(ex(4'd3, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0), "pre_tick");
        nopc(ex(4'd2, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0), "tick_29");
        nop(3);
        nopc(ex(4'd2, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0), "tick_28");

        // Count 10 down to expiry
        do_load(4'd1, 4'd0, ex(4'd1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0), "load_10");
        do_start(ex(4'd1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0), "start_10");
        nop(2);
        nopc(ex(4'd1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0), "hold_10");
        nopc(ex(4'd0, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0), "wrap_09");
        nop(14);
        nopc(ex(4'd0, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0), "pre_warn_06");
        nopc(ex(4'd0, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0), "warn_05");
        nop(18);
        nopc(ex(4'd0, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0), "hold_01");
        nopc(ex(4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1), "expire_pulse");
        nopc(ex(4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0), "pulse_one_cycle");
        do_start(ex(4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0), "start_in_expired");
        do_bonus(ex(4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0), "bonus_in_expired");

        // Pause / resume phase keeping
        do_load(4'd2, 4'd0, ex(4'd2, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0), "load_clears_exp");
        do_start(ex(4'd2, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0), "start_20");
        nop(2);
        do_pause(ex(4'd2, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0), "pause_p2");
        nop(19);
        nopc(ex(4'd2, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0), "frozen");
        do_start(ex(4'd2, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0), "resume");
        nopc(ex(4'd1, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0), "resume_tick");
        nop(3);
        do_pause(ex(4'd1, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0), "pause_on_tick");
        do_start(ex(4'd1, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0), "resume2");
        nopc(ex(4'd1, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0), "deferred_tick");

        // Bonus
        do_load(4'd9, 4'd7, ex(4'd9, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0), "load_97");
        do_bonus(ex(4'd9, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0), "bonus_idle");
        do_start(ex(4'd9, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0), "start_97");
        do_bonus(ex(4'd9, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0), "bonus_sat_99");
        do_load(4'd1, 4'd2, ex(4'd1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0), "load_12");
        do_start(ex(4'd1, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0), "start_12");
        nop(2);
        nopc(ex(4'd1, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0), "pre_bonus_tick");
        do_bonus(ex(4'd1, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0), "bonus_with_tick");

        // Clamp and zero start
        do_load(4'hC, 4'hF, ex(4'd9, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0), "load_clamp");
        do_load(4'd0, 4'd0, ex(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0), "load_00");
        do_start(ex(4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1), "start_zero");
        nopc(ex(4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0), "zero_pulse_clear");

        // Reset mid-RUN with load and start also asserted
        do_load(4'd5, 4'd0, ex(4'd5, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0), "load_50");
        do_start(ex(4'd5, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0), "start_50");
        nop(2);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 4'd7, 4'd7, 1'b0, 1'b1, ex(4'd3, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0), "reset_mid_run");
        nopc(ex(4'd3, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0), "idle_after_rst");
        do_start(ex(4'd3, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0), "start_after_rst");
        nop(3);
        nopc(ex(4'd2, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0), "tick_after_rst");

        // Let the monitor drain the queue, bounded
        for (int i = 0; i < 5 && sb_q.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
